// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants: datapath width, index width and
// the architecturally special register indices.
package mips_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_cell.sv
// Single WIDTH-bit storage cell with load enable and asynchronous active-low
// clear; the register file builds its general-purpose registers from these.
module regfile_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mips_regfile.sv
// 2-read / 1-write MIPS general-purpose register file with $0 hardwired to
// zero and optional write-first forwarding onto the read ports.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int WIDTH  = REG_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];

    // $0 has no storage; only indices 1..DEPTH-1 get a cell and a decode term.
    assign regs[REG_ZERO] = '0;

    generate
        for (genvar i = 1; i < DEPTH; i++) begin : g_cell
            logic cell_en;

            assign cell_en = we && (waddr == ADDR_W'(i));

            regfile_cell #(
                .WIDTH(WIDTH)
            ) u_cell (
                .clk  (clk),
                .rst_n(reset),
                .en   (cell_en),
                .d    (wdata),
                .q    (regs[i])
            );
        end
    endgenerate

    // A write that will actually land at the next edge; gating with reset keeps
    // the ports at zero while the array is being cleared.
    logic wr_live;
    assign wr_live = reset && we && (waddr != ADDR_W'(REG_ZERO));

    always_comb begin
        rdata1 = regs[raddr1];
        if ((BYPASS != 0) && wr_live && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if ((BYPASS != 0) && wr_live && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: tb/tb_mips_regfile.sv
// Directed and scoreboarded checks of mips_regfile: reset, write/read,
// $0 protection, forwarding, asynchronous reset and a random run.
module tb_mips_regfile;
    import mips_pkg::*;

    localparam int TB_BYPASS = 1;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_regs [32];

    mips_regfile #(
        .WIDTH (32),
        .ADDR_W(5),
        .BYPASS(TB_BYPASS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr1(raddr1),
        .raddr2(raddr2),
        .rdata1(rdata1),
        .rdata2(rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        raddr1 = a1;
        raddr2 = a2;
        #1;
    endtask

    initial begin
        logic [31:0] exp1;
        logic [31:0] exp2;

        reset  = 1'b0;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;

        // Write presented during reset: ports stay zero and the write is lost.
        #3;
        we     = 1'b1;
        waddr  = 5'd3;
        wdata  = 32'hCAFE_0003;
        raddr1 = 5'd3;
        raddr2 = 5'd3;
        #1;
        check("reset_bypass_p1", rdata1, 32'h0);
        check("reset_bypass_p2", rdata2, 32'h0);
        #3;
        we = 1'b0;
        #15;
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(31 - i));
            check("reset_read_p1", rdata1, 32'h0);
            check("reset_read_p2", rdata2, 32'h0);
        end

        do_write(5'd5, 32'hDEAD_BEEF);
        do_read(5'd5, 5'd6);
        check("write5_p1", rdata1, 32'hDEAD_BEEF);
        check("write6_p2", rdata2, 32'h0);

        // $0 protection, including during the write cycle itself.
        @(negedge clk);
        we     = 1'b1;
        waddr  = 5'd0;
        wdata  = 32'hFFFF_FFFF;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        #1;
        check("zero_during_write_p1", rdata1, 32'h0);
        check("zero_during_write_p2", rdata2, 32'h0);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("zero_after_write_p1", rdata1, 32'h0);
        do_read(5'd5, 5'd0);
        check("zero_write_no_alias", rdata1, 32'hDEAD_BEEF);

        // Forwarding on both ports, then on one port only.
        do_write(5'd7, 32'h11);
        do_read(5'd7, 5'd7);
        check("r7_before_p1", rdata1, 32'h11);
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd7;
        wdata = 32'h22;
        #1;
        check("bypass_p1", rdata1, (TB_BYPASS != 0) ? 32'h22 : 32'h11);
        check("bypass_p2", rdata2, (TB_BYPASS != 0) ? 32'h22 : 32'h11);
        raddr1 = 5'd5;
        #1;
        check("bypass_miss_p1", rdata1, 32'hDEAD_BEEF);
        check("bypass_hit_p2", rdata2, (TB_BYPASS != 0) ? 32'h22 : 32'h11);
        @(negedge clk);
        we     = 1'b0;
        raddr1 = 5'd7;
        #1;
        check("r7_after_p1", rdata1, 32'h22);
        check("r7_after_p2", rdata2, 32'h22);

        // Fill 1..31 with index*3 and verify a few, including $sp and $ra.
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i * 3));
        end
        do_read(5'(REG_RA), 5'(REG_SP));
        check("fill_ra", rdata1, 32'd93);
        check("fill_sp", rdata2, 32'd87);
        do_read(5'd1, 5'd16);
        check("fill_r1", rdata1, 32'd3);
        check("fill_r16", rdata2, 32'd48);

        // Short reset pulse between edges clears everything immediately.
        raddr1 = 5'(REG_RA);
        raddr2 = 5'(REG_SP);
        #1;
        reset = 1'b0;
        #1;
        check("async_clr_ra", rdata1, 32'h0);
        check("async_clr_sp", rdata2, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        check("post_pulse_ra", rdata1, 32'h0);
        do_read(5'd1, 5'd16);
        check("post_pulse_r1", rdata1, 32'h0);
        check("post_pulse_r16", rdata2, 32'h0);

        // Write held across an edge while reset is low must be discarded.
        @(negedge clk);
        reset  = 1'b0;
        we     = 1'b1;
        waddr  = 5'd10;
        wdata  = 32'h0000_0ABC;
        raddr1 = 5'd10;
        #1;
        check("reset_write_bypass", rdata1, 32'h0);
        @(posedge clk);
        #2;
        we    = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_write_lost", rdata1, 32'h0);

        do_write(5'd10, 32'h55);
        do_read(5'd10, 5'd11);
        check("first_write_after_release", rdata1, 32'h55);
        check("neighbour_untouched", rdata2, 32'h0);

        // Random scoreboard run.
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        ref_regs[10] = 32'h55;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            we     = ($urandom_range(0, 2) != 0);
            waddr  = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            #1;
            exp1 = ref_regs[raddr1];
            exp2 = ref_regs[raddr2];
            if (TB_BYPASS != 0 && we && waddr != 5'd0) begin
                if (raddr1 == waddr) exp1 = wdata;
                if (raddr2 == waddr) exp2 = wdata;
            end
            if (raddr1 == 5'd0) exp1 = 32'h0;
            if (raddr2 == 5'd0) exp2 = 32'h0;
            check("rand_p1", rdata1, exp1);
            check("rand_p2", rdata2, exp2);
            if (we && waddr != 5'd0) ref_regs[waddr] = wdata;
        end
        @(negedge clk);
        we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
